// File: rtl/keypad_pkg.sv
// Shared types and timing helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_DRIVE,
    ST_SAMPLE,
    ST_HOLD
  } scan_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } result_e;

  function automatic int ticks_for_us(input int clk_hz, input int us);
    return (clk_hz / 1000000) * us;
  endfunction

  // Saturating hit count of one full scan mapped to its scan result.
  function automatic result_e classify(input logic [1:0] hit_cnt);
    case (hit_cnt)
      2'd0:    return RES_NONE;
      2'd1:    return RES_KEY;
      default: return RES_MULTI;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_n_if.sv
// Keypad pin and key-event bundle between the scanner and its consumer.
interface keypad_scanner_n_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int KEY_W = $clog2(ROWS * COLS)
);
  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_press;
  logic             key_release;
  logic             multi_key;

  modport master (
    input  row,
    output col, key_code, key_valid, key_press, key_release, multi_key
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_press, key_release, multi_key
  );
endinterface

// File: rtl/keypad_debouncer.sv
// Scan-result debouncer: candidate/count tracking, accepted key and event pulses.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int KEY_W          = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             eval_i,
  input  result_e          res_kind_i,
  input  logic [KEY_W-1:0] res_code_i,
  output logic [KEY_W-1:0] key_code_o,
  output logic             key_valid_o,
  output logic             key_press_o,
  output logic             key_release_o,
  output logic             multi_key_o
);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("keypad_debouncer: DEBOUNCE_SCANS must be in 1..15");
  end

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  result_e          cand_kind_q, cand_kind_d;
  logic [KEY_W-1:0] cand_code_q, cand_code_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             multi_q, multi_d;
  logic             pend_q, pend_d;
  logic [KEY_W-1:0] pend_code_q, pend_code_d;
  logic             same;

  always_comb begin
    cand_kind_d = cand_kind_q;
    cand_code_d = cand_code_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    valid_d     = valid_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    multi_d     = 1'b0;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    same        = (res_kind_i == cand_kind_q) &&
                  (res_kind_i != RES_KEY || res_code_i == cand_code_q);

    // Second half of a direct key-to-key change: press follows the release.
    if (pend_q) begin
      code_d  = pend_code_q;
      valid_d = 1'b1;
      press_d = 1'b1;
    end

    if (eval_i) begin
      if (res_kind_i == RES_MULTI) begin
        multi_d = 1'b1;
        cnt_d   = 4'd0;
      end else begin
        if (same) begin
          cnt_d = (cnt_q >= DEB) ? DEB : cnt_q + 4'd1;
        end else begin
          cand_kind_d = res_kind_i;
          cand_code_d = res_code_i;
          cnt_d       = 4'd1;
        end
        if (cnt_d == DEB) begin
          if (cand_kind_d == RES_NONE) begin
            if (valid_q) begin
              release_d = 1'b1;
              valid_d   = 1'b0;
            end
          end else if (!valid_q) begin
            code_d  = cand_code_d;
            valid_d = 1'b1;
            press_d = 1'b1;
          end else if (cand_code_d != code_q) begin
            release_d   = 1'b1;
            valid_d     = 1'b0;
            pend_d      = 1'b1;
            pend_code_d = cand_code_d;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_kind_q <= RES_NONE;
      cand_code_q <= '0;
      cnt_q       <= 4'd0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      multi_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
    end else begin
      cand_kind_q <= cand_kind_d;
      cand_code_q <= cand_code_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
      multi_q     <= multi_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
    end
  end

  assign key_code_o    = code_q;
  assign key_valid_o   = valid_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign multi_key_o   = multi_q;

endmodule

// File: rtl/keypad_scanner_n.sv
// Matrix keypad scanner: column drive timing, row sampling and per-scan hit accumulation.
module keypad_scanner_n
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int COL_PERIOD_US  = 1000,
  parameter int SETTLE_US      = 1,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_n_if.master bus
);

  localparam int KEY_W        = $clog2(ROWS * COLS);
  localparam int COL_TICKS    = ticks_for_us(CLK_HZ, COL_PERIOD_US);
  localparam int SETTLE_TICKS = ticks_for_us(CLK_HZ, SETTLE_US);
  localparam int TICK_W       = (COL_TICKS > 1) ? $clog2(COL_TICKS) : 1;
  localparam int COL_W        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (SETTLE_TICKS < 1 || SETTLE_TICKS > COL_TICKS - 2) begin : g_bad_timing
    $error("keypad_scanner_n: need 1 <= SETTLE_TICKS <= COL_TICKS-2");
  end

  scan_state_e      state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [COLS-1:0]  col_q, col_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [KEY_W-1:0] first_code_q, first_code_d;
  result_e          res_kind_q, res_kind_d;
  logic [KEY_W-1:0] res_code_q, res_code_d;
  logic             eval_q, eval_d;

  logic [ROWS-1:0]  hits;
  logic [1:0]       col_hits;
  logic [ROW_W-1:0] col_first;
  logic [KEY_W-1:0] col_code;
  logic [2:0]       hit_sum;
  logic             last_tick;

  assign hits = ~bus.row;

  // Hits in the currently driven column; the lowest row wins as first hit.
  always_comb begin
    col_hits  = 2'd0;
    col_first = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        col_first = ROW_W'(i);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  assign col_code  = KEY_W'(int'(col_first) * COLS + int'(col_idx_q));
  assign hit_sum   = {1'b0, hit_cnt_q} + {1'b0, col_hits};
  assign last_tick = (tick_q == TICK_W'(COL_TICKS - 1));

  always_comb begin
    state_d      = state_q;
    tick_d       = last_tick ? '0 : tick_q + TICK_W'(1);
    col_idx_d    = col_idx_q;
    hit_cnt_d    = hit_cnt_q;
    first_code_d = first_code_q;
    res_kind_d   = res_kind_q;
    res_code_d   = res_code_q;
    eval_d       = 1'b0;

    case (state_q)
      ST_DRIVE: begin
        if (tick_q == TICK_W'(SETTLE_TICKS - 1)) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d = ST_HOLD;
        if (col_hits != 2'd0) begin
          if (hit_cnt_q == 2'd0) first_code_d = col_code;
          hit_cnt_d = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        end
      end
      ST_HOLD: begin
        if (last_tick) begin
          state_d = ST_DRIVE;
          if (col_idx_q == COL_W'(COLS - 1)) begin
            // Scan complete: hand the result over and start a fresh scan.
            col_idx_d    = '0;
            eval_d       = 1'b1;
            res_kind_d   = classify(hit_cnt_q);
            res_code_d   = first_code_q;
            hit_cnt_d    = 2'd0;
            first_code_d = '0;
          end else begin
            col_idx_d = col_idx_q + COL_W'(1);
          end
        end
      end
      default: state_d = ST_DRIVE;
    endcase

    col_d = ~(COLS'(1) << col_idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DRIVE;
      tick_q       <= '0;
      col_idx_q    <= '0;
      col_q        <= '1;
      hit_cnt_q    <= 2'd0;
      first_code_q <= '0;
      res_kind_q   <= RES_NONE;
      res_code_q   <= '0;
      eval_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      hit_cnt_q    <= hit_cnt_d;
      first_code_q <= first_code_d;
      res_kind_q   <= res_kind_d;
      res_code_q   <= res_code_d;
      eval_q       <= eval_d;
    end
  end

  assign bus.col = col_q;

  keypad_debouncer #(
    .KEY_W         (KEY_W),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk          (clk),
    .rst          (rst),
    .eval_i       (eval_q),
    .res_kind_i   (res_kind_q),
    .res_code_i   (res_code_q),
    .key_code_o   (bus.key_code),
    .key_valid_o  (bus.key_valid),
    .key_press_o  (bus.key_press),
    .key_release_o(bus.key_release),
    .multi_key_o  (bus.multi_key)
  );

endmodule
